instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Responder for the multi-cycle controller's IF-stage handshake.
- Owns the PC. Answers the controller's instrre pulse by reading instruction memory and latching the instruction word. Applies pcnextctl/pcmuxctl PC updates.
- Sits between the controller FSM and the instruction memory port, feeding instr to decode and the EX-stage control logic.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- pcmux_N, 2, number of PC mux sources (must match the controller).
- TIMEOUT_CYC, 15, max wait cycles for imem_ack (used only with IFU_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instrre  in  1  fetch request from controller, single-cycle pulse.
- pcnextctl  in  1  PC update strobe from controller.
- pcmuxctl  in  $clog2(pcmux_N)  PC source select.
- brtarget  in  XLEN  branch/jump target from EX.
- pc  out  XLEN  current PC.
- instr  out  32  latched instruction register.
- instr_valid  out  1  instr holds the word fetched for the current PC.
- fetch_busy  out  1  fetch outstanding.
- fetch_err  out  1  sticky error (misaligned PC or timeout).
- imem_req  out  1  memory read request.
- imem_addr  out  XLEN  memory read address.
- imem_rdata  in  32  memory read data.
- imem_ack  in  1  memory read complete; imem_rdata valid this cycle.

Behaviour:
- Reset (async, rst_n=0), all registers take these values immediately:
  - pc=RESET_PC; instr=32'h0000_0013 (NOP).
  - instr_valid=0; fetch_busy=0; fetch_err=0.
  - imem_req=0; imem_addr=0; FSM=IDLE.
- pc_next (combinational):
  - pcmuxctl=0 → pc+4, wrapping modulo 2^XLEN.
  - pcmuxctl=1 → brtarget.
  - Any other code → pc+4.
- FSM states: IDLE, WAIT, ERR.
- IDLE:
  - pcnextctl=1 → pc<=pc_next; instr_valid<=0.
  - instrre=1 → fetch address is the PC as updated this edge (pc_next if pcnextctl is also 1, else pc).
    - Address[1:0]≠0 → fetch_err<=1, FSM to ERR, no memory request issued.
    - Otherwise → imem_req<=1, imem_addr<=address, fetch_busy<=1, instr_valid<=0, FSM to WAIT.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, imem_req<=0, fetch_busy<=0, FSM to IDLE. Fetch latency is 1 cycle plus memory wait; minimum 2 edges from instrre to instr_valid.
  - instrre in WAIT is ignored.
  - pcnextctl in WAIT is deferred: the pc_next value is captured in a pending register and applied on the ack edge. In that case instr_valid stays 0, because the fetched word belongs to the old PC.
- ERR:
  - fetch_err and FSM hold until reset.
  - pc and pcnextctl updates still apply; instrre is ignored.
- imem_ack outside WAIT is ignored.
- Reset mid-fetch: imem_req drops asynchronously; any in-flight ack is discarded.

Optional Feature:
- Macro IFU_TIMEOUT_EN.
- Defined: a 4-bit-minimum counter ($clog2(TIMEOUT_CYC+1) bits) counts WAIT cycles, cleared on entering WAIT. Reaching TIMEOUT_CYC with no ack → imem_req<=0, fetch_busy<=0, fetch_err<=1, FSM to ERR.
- Undefined: WAIT holds indefinitely; no counter logic is synthesised.

Decomposition:
- Shared package cpu_pkg holds:
  - PC mux encodings PCSEL_PLUS4=0, PCSEL_BRANCH=1.
  - IFU FSM state enum.
  - NOP encoding 32'h0000_0013.
  - RESET_PC default.
- One natural sub-module: pc_next_mux (combinational pc_next selection), reusable by a future pipelined fetch.

Test Plan:
- Basic fetch: release reset; instrre pulse; imem_ack with rdata=32'h00500093 after 3 cycles → imem_addr=0 held 3 cycles, instr=32'h00500093, instr_valid=1 on the ack edge, fetch_busy back to 0.
- Sequential PC: pcnextctl with pcmuxctl=0 three times from pc=0 → pc=12. At pc=32'hFFFF_FFFC, one more increment → pc=0 (wrap).
- Branch + simultaneous fetch: pcnextctl=1, pcmuxctl=1, brtarget=32'h0000_0100, instrre=1 on the same edge → imem_addr=32'h100, pc=32'h100.
- Misaligned: brtarget=32'h102 applied, then instrre → fetch_err=1, imem_req never asserts, further instrre ignored until rst_n low.
- Deferred update: pcnextctl during WAIT (pc=8, pcmuxctl=0), then ack → pc=12, instr_valid=0. Assert rst_n=0 mid-WAIT → imem_req=0 immediately.
- IFU_TIMEOUT_EN, TIMEOUT_CYC=15: instrre with no ack → fetch_err=1 and imem_req=0 after 15 WAIT cycles. Without the macro, no error after 100 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC mux encodings, IFU state enum, NOP and reset PC.
package cpu_pkg;

    localparam int PCSEL_PLUS4  = 0;
    localparam int PCSEL_BRANCH = 1;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_WAIT = 2'd1,
        IFU_ERR  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: sequential PC+4 or branch/jump target.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int SEL_W = 1
) (
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  brtarget,
    input  logic [SEL_W-1:0] pcmuxctl,
    output logic [XLEN-1:0]  pc_next
);

    localparam logic [SEL_W-1:0] SEL_PLUS4  = SEL_W'(PCSEL_PLUS4);
    localparam logic [SEL_W-1:0] SEL_BRANCH = SEL_W'(PCSEL_BRANCH);

    // Unassigned select codes fall back to sequential flow.
    always_comb begin
        pc_next = pc + XLEN'(4);
        case (pcmuxctl)
            SEL_PLUS4:  pc_next = pc + XLEN'(4);
            SEL_BRANCH: pc_next = brtarget;
            default:    pc_next = pc + XLEN'(4);
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage responder: owns the PC, fetches from instruction memory on instrre.
// Optional IFU_TIMEOUT_EN adds an imem_ack watchdog that raises fetch_err.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
    parameter int              pcmux_N     = 2,
    parameter int              TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       instrre,
    input  logic                       pcnextctl,
    input  logic [$clog2(pcmux_N)-1:0] pcmuxctl,
    input  logic [XLEN-1:0]            brtarget,
    output logic [XLEN-1:0]            pc,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic                       fetch_busy,
    output logic                       fetch_err,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_ack
);

    localparam int SEL_W = $clog2(pcmux_N);

    if (pcmux_N < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("instr_fetch_unit: pcmux_N must be >= 2 and TIMEOUT_CYC >= 1");
    end

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            fetch_busy_q, fetch_busy_d;
    logic            fetch_err_q, fetch_err_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic            pend_q, pend_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic [XLEN-1:0] pc_base;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] fetch_addr;
    logic            pc_deferred;

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) < 4) ? 4 : $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Deferred updates chain from the pending value so repeated strobes in WAIT accumulate.
    assign pc_base = pend_q ? pend_pc_q : pc_q;

    pc_next_mux #(
        .XLEN  (XLEN),
        .SEL_W (SEL_W)
    ) u_pc_next_mux (
        .pc       (pc_base),
        .brtarget (brtarget),
        .pcmuxctl (pcmuxctl),
        .pc_next  (pc_nxt)
    );

    assign pc_deferred = pend_q | pcnextctl;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_busy_d  = fetch_busy_q;
        fetch_err_d   = fetch_err_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        fetch_addr    = pcnextctl ? pc_nxt : pc_q;
`ifdef IFU_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif
        case (state_q)
            IFU_IDLE: begin
                if (pcnextctl) begin
                    pc_d          = pc_nxt;
                    instr_valid_d = 1'b0;
                end
                if (instrre) begin
                    if (fetch_addr[1:0] != 2'b00) begin
                        fetch_err_d = 1'b1;
                        state_d     = IFU_ERR;
                    end else begin
                        imem_req_d    = 1'b1;
                        imem_addr_d   = fetch_addr;
                        fetch_busy_d  = 1'b1;
                        instr_valid_d = 1'b0;
                        state_d       = IFU_WAIT;
`ifdef IFU_TIMEOUT_EN
                        tmo_cnt_d     = CNT_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
            end
            IFU_WAIT: begin
                if (pcnextctl) begin
                    pend_d    = 1'b1;
                    pend_pc_d = pc_nxt;
                end
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = ~pc_deferred;
                    imem_req_d    = 1'b0;
                    fetch_busy_d  = 1'b0;
                    state_d       = IFU_IDLE;
                    pend_d        = 1'b0;
                    if (pc_deferred) pc_d = pcnextctl ? pc_nxt : pend_pc_q;
                end
`ifdef IFU_TIMEOUT_EN
                else if (tmo_cnt_q == '0) begin
                    imem_req_d   = 1'b0;
                    fetch_busy_d = 1'b0;
                    fetch_err_d  = 1'b1;
                    state_d      = IFU_ERR;
                    pend_d       = 1'b0;
                    if (pc_deferred) pc_d = pcnextctl ? pc_nxt : pend_pc_q;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
            end
            IFU_ERR: begin
                if (pcnextctl) begin
                    pc_d          = pc_nxt;
                    instr_valid_d = 1'b0;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IFU_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_busy_q  <= 1'b0;
            fetch_err_q   <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            pend_q        <= 1'b0;
            pend_pc_q     <= '0;
`ifdef IFU_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_busy_q  <= fetch_busy_d;
            fetch_err_q   <= fetch_err_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
`ifdef IFU_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_busy  = fetch_busy_q;
    assign fetch_err   = fetch_err_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized
// fetch/PC-update traffic checked against an arithmetic model of the PC rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instrre = 1'b0;
    logic        pcnextctl = 1'b0;
    logic [0:0]  pcmuxctl = 1'b0;
    logic [31:0] brtarget = '0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_err;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch_unit #(
        .XLEN        (32),
        .RESET_PC    (32'h0000_0000),
        .pcmux_N     (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instrre     (instrre),
        .pcnextctl   (pcnextctl),
        .pcmuxctl    (pcmuxctl),
        .brtarget    (brtarget),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack)
    );

    always #5 clk = ~clk;

    // One clock edge, then settle away from the edge; pulses are cleared afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        instrre   = 1'b0;
        pcnextctl = 1'b0;
        imem_ack  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        instrre = 1'b0; pcnextctl = 1'b0; imem_ack = 1'b0; pcmuxctl = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 32'h0)           begin n_bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        n_cmp++; if (instr !== 32'h13)       begin n_bad++; $display("FAIL reset_instr got %h exp %h", instr, 32'h13); end
        n_cmp++; if (instr_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        n_cmp++; if (fetch_busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b exp 0", fetch_busy); end
        n_cmp++; if (fetch_err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got %b exp 0", fetch_err); end
        n_cmp++; if (imem_req !== 1'b0)      begin n_bad++; $display("FAIL reset_req got %b exp 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0)    begin n_bad++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        instrre = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_busy !== 1'b1)
                begin n_bad++; $display("FAIL basic_wait[%0d] req=%b addr=%h busy=%b exp 1/0/1", i, imem_req, imem_addr, fetch_busy); end
            if (i < 2) tick();
        end
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        n_cmp++; if (instr !== 32'h0050_0093) begin n_bad++; $display("FAIL basic_instr got %h exp %h", instr, 32'h0050_0093); end
        n_cmp++; if (instr_valid !== 1'b1 || fetch_busy !== 1'b0 || imem_req !== 1'b0)
            begin n_bad++; $display("FAIL basic_done valid=%b busy=%b req=%b exp 1/0/0", instr_valid, fetch_busy, imem_req); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pcnextctl = 1'b1; pcmuxctl = 1'b0;
            tick();
        end
        n_cmp++; if (pc !== 32'd12) begin n_bad++; $display("FAIL seq_pc got %h exp %h", pc, 32'd12); end
        pcnextctl = 1'b1; pcmuxctl = 1'b1; brtarget = 32'hFFFF_FFFC;
        tick();
        pcnextctl = 1'b1; pcmuxctl = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL seq_wrap got %h exp 0", pc); end
    endtask

    task automatic test_branch_fetch();
        do_reset();
        pcnextctl = 1'b1; pcmuxctl = 1'b1; brtarget = 32'h100; instrre = 1'b1;
        tick();
        n_cmp++; if (imem_addr !== 32'h100 || pc !== 32'h100 || imem_req !== 1'b1)
            begin n_bad++; $display("FAIL branch_fetch addr=%h pc=%h req=%b exp 100/100/1", imem_addr, pc, imem_req); end
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_0013;
        tick();
        n_cmp++; if (instr !== 32'hCAFE_0013 || instr_valid !== 1'b1)
            begin n_bad++; $display("FAIL branch_instr got %h/%b exp cafe0013/1", instr, instr_valid); end
    endtask

    task automatic test_misaligned();
        do_reset();
        pcnextctl = 1'b1; pcmuxctl = 1'b1; brtarget = 32'h102;
        tick();
        instrre = 1'b1;
        tick();
        n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0)
            begin n_bad++; $display("FAIL misalign_err err=%b req=%b exp 1/0", fetch_err, imem_req); end
        for (int i = 0; i < 4; i++) begin
            instrre = 1'b1; imem_ack = 1'b1;
            tick();
            n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || fetch_busy !== 1'b0)
                begin n_bad++; $display("FAIL misalign_hold[%0d] err=%b req=%b busy=%b exp 1/0/0", i, fetch_err, imem_req, fetch_busy); end
        end
        pcnextctl = 1'b1; pcmuxctl = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h106) begin n_bad++; $display("FAIL err_pc_update got %h exp 106", pc); end
        do_reset();
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got %b exp 0", fetch_err); end
    endtask

    task automatic test_deferred();
        do_reset();
        pcnextctl = 1'b1; pcmuxctl = 1'b1; brtarget = 32'h8; instrre = 1'b1;
        tick();
        pcnextctl = 1'b1; pcmuxctl = 1'b0;
        tick();
        n_cmp++; if (pc !== 32'h8 || imem_addr !== 32'h8)
            begin n_bad++; $display("FAIL defer_hold pc=%h addr=%h exp 8/8", pc, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        n_cmp++; if (pc !== 32'd12 || instr_valid !== 1'b0 || instr !== 32'h1234_5678)
            begin n_bad++; $display("FAIL defer_apply pc=%h valid=%b instr=%h exp c/0/12345678", pc, instr_valid, instr); end
        instrre = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0)
            begin n_bad++; $display("FAIL reset_midwait req=%b busy=%b exp 0/0", imem_req, fetch_busy); end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        n_cmp++; if (instr !== 32'h13 || instr_valid !== 1'b0)
            begin n_bad++; $display("FAIL reset_discard instr=%h valid=%b exp 13/0", instr, instr_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        instrre = 1'b1;
        tick();
`ifdef IFU_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i < 15) begin
                n_cmp++; if (fetch_err !== 1'b0 || imem_req !== 1'b1)
                    begin n_bad++; $display("FAIL tmo_early[%0d] err=%b req=%b exp 0/1", i, fetch_err, imem_req); end
            end
        end
        n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || fetch_busy !== 1'b0)
            begin n_bad++; $display("FAIL tmo_fire err=%b req=%b busy=%b exp 1/0/0", fetch_err, imem_req, fetch_busy); end
`else
        repeat (100) tick();
        n_cmp++; if (fetch_err !== 1'b0 || imem_req !== 1'b1 || fetch_busy !== 1'b1)
            begin n_bad++; $display("FAIL no_tmo err=%b req=%b busy=%b exp 0/1/1", fetch_err, imem_req, fetch_busy); end
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0013;
        tick();
        n_cmp++; if (instr !== 32'hA5A5_0013 || instr_valid !== 1'b1)
            begin n_bad++; $display("FAIL no_tmo_ack instr=%h valid=%b exp a5a50013/1", instr, instr_valid); end
`endif
    endtask

    // Model: PC is plain 32-bit arithmetic; a fetch reads the PC after this edge's update;
    // updates during a fetch are queued and take effect when the word returns.
    task automatic test_random();
        logic [31:0] m_pc, m_instr, m_pend, tgt, addr;
        logic        m_valid, have_pend, upd, br;
        do_reset();
        m_pc = 32'h0; m_instr = 32'h13; m_valid = 1'b0;
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                br = ($urandom_range(0, 2) == 0);
                tgt = $urandom() & 32'hFFFF_FFFC;
                pcnextctl = 1'b1; pcmuxctl = br; brtarget = tgt;
                m_pc = br ? tgt : m_pc + 32'd4; m_valid = 1'b0;
                tick();
            end
            n_cmp++; if (pc !== m_pc || instr_valid !== m_valid)
                begin n_bad++; $display("FAIL rnd_idle[%0d] pc=%h valid=%b exp %h/%b", it, pc, instr_valid, m_pc, m_valid); end
            upd = $urandom_range(0, 1); br = $urandom_range(0, 1);
            tgt = $urandom() & 32'hFFFF_FFFC;
            instrre = 1'b1; pcnextctl = upd; pcmuxctl = br; brtarget = tgt;
            if (upd) m_pc = br ? tgt : m_pc + 32'd4;
            addr = m_pc;
            tick();
            have_pend = 1'b0; m_pend = m_pc;
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                if ($urandom_range(0, 3) == 0) begin
                    br = $urandom_range(0, 1); tgt = $urandom() & 32'hFFFF_FFFC;
                    pcnextctl = 1'b1; pcmuxctl = br; brtarget = tgt;
                    m_pend = br ? tgt : m_pend + 32'd4; have_pend = 1'b1;
                end
                instrre = $urandom_range(0, 1);
                tick();
                n_cmp++; if (imem_req !== 1'b1 || imem_addr !== addr || pc !== m_pc)
                    begin n_bad++; $display("FAIL rnd_wait[%0d] req=%b addr=%h pc=%h exp 1/%h/%h", it, imem_req, imem_addr, pc, addr, m_pc); end
            end
            m_instr = $urandom();
            imem_ack = 1'b1; imem_rdata = m_instr;
            if (have_pend) m_pc = m_pend;
            m_valid = ~have_pend;
            tick();
            n_cmp++; if (instr !== m_instr || instr_valid !== m_valid || pc !== m_pc || fetch_busy !== 1'b0)
                begin n_bad++; $display("FAIL rnd_ack[%0d] instr=%h valid=%b pc=%h busy=%b exp %h/%b/%h/0",
                                        it, instr, instr_valid, pc, fetch_busy, m_instr, m_valid, m_pc); end
            imem_ack = 1'b1;
            tick();
            n_cmp++; if (instr !== m_instr || fetch_busy !== 1'b0)
                begin n_bad++; $display("FAIL rnd_stray_ack[%0d] instr=%h busy=%b exp %h/0", it, instr, fetch_busy, m_instr); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_sequential();
        test_branch_fetch();
        test_misaligned();
        test_deferred();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
